// File: rtl/ddr_burst_mover.sv
// Moves data between the host pipe FIFOs and the DDR2 local interface in the phy_clk domain.
// Writes pack two 32-bit pipe-in words per beat; reads are flow-controlled against readback FIFO space.
module ddr_burst_mover #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 64,
  parameter int RF_DEPTH = 512,
  parameter int RF_UW    = 9,
  parameter int MAX_OUT  = 8
) (
  input  logic                phy_clk,
  input  logic                reset_phy_clk_n,
  input  logic                local_init_done,
  input  logic                start_write,
  input  logic                start_read,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_beats,
  input  logic                wf_empty,
  input  logic [31:0]         wf_q,
  output logic                wf_rdreq,
  input  logic [RF_UW-1:0]    rf_usedw,
  output logic [DATA_W-1:0]   rf_data,
  output logic                rf_wrreq,
  output logic [ADDR_W-1:0]   local_address,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  output logic                local_size,
  output logic                local_burstbegin,
  output logic                local_write_req,
  output logic                local_read_req,
  input  logic                local_ready,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int OUT_W = 4;

  typedef enum logic [2:0] {IDLE, W_FETCH0, W_FETCH1, W_REQ, R_ISSUE, R_DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [31:0]         wlo_q, wlo_d, whi_q, whi_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                held_q, held_d;
  logic                rf_wrreq_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic                done_q, err_q, err_d;
  logic [31:0]         fill;
  logic                can_issue, rd_acc, rv;

  // Projected readback occupancy if one more read were issued now.
  assign fill      = 32'(rf_usedw) + 32'(out_q) + 32'd1;
  assign can_issue = (out_q < OUT_W'(MAX_OUT)) && (fill <= 32'(RF_DEPTH));
  assign rv        = local_rdata_valid && (out_q != '0);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    wlo_d           = wlo_q;
    whi_d           = whi_q;
    wf_rdreq        = 1'b0;
    local_write_req = 1'b0;
    local_read_req  = 1'b0;
    unique case (state_q)
      IDLE: if (local_init_done && (start_write || start_read)) begin
        addr_d = base_addr;
        rem_d  = num_beats;
        if (num_beats == '0)  state_d = FIN;
        else if (start_write) state_d = W_FETCH0;
        else                  state_d = R_ISSUE;
      end
      W_FETCH0: if (!wf_empty) begin
        wf_rdreq = 1'b1;
        wlo_d    = wf_q;
        state_d  = W_FETCH1;
      end
      W_FETCH1: if (!wf_empty) begin
        wf_rdreq = 1'b1;
        whi_d    = wf_q;
        state_d  = W_REQ;
      end
      W_REQ: begin
        local_write_req = 1'b1;
        if (local_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = (rem_q == ADDR_W'(1)) ? FIN : W_FETCH0;
        end
      end
      R_ISSUE: begin
        // Once presented, a read stays up until accepted even if the credit check drops.
        local_read_req = held_q || can_issue;
        if (local_read_req && local_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = R_DRAIN;
        end
      end
      R_DRAIN: if (out_q == '0 && !rf_wrreq_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_acc = local_read_req && local_ready;
    unique case ({rd_acc, rv})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
    held_d = (local_write_req || local_read_req) && !local_ready;
    err_d  = err_q || (local_rdata_valid && out_q == '0);
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      wlo_q      <= '0;
      whi_q      <= '0;
      out_q      <= '0;
      held_q     <= 1'b0;
      rf_wrreq_q <= 1'b0;
      rf_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wlo_q      <= wlo_d;
      whi_q      <= whi_d;
      out_q      <= out_d;
      held_q     <= held_d;
      rf_wrreq_q <= rv;
      if (rv) rf_data_q <= local_rdata;
      // done lands the cycle after FIN, i.e. two cycles after an empty-job start.
      done_q     <= (state_q == FIN);
      err_q      <= err_d;
    end
  end

  assign local_address    = addr_q;
  assign local_wdata      = DATA_W'({whi_q, wlo_q});
  assign local_be         = '1;
  assign local_size       = 1'b1;
  assign local_burstbegin = (local_write_req || local_read_req) && !held_q;
  assign rf_wrreq         = rf_wrreq_q;
  assign rf_data          = rf_data_q;
  assign busy             = (state_q != IDLE) && (state_q != FIN);
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_ddr_burst_mover.sv
// Directed bench for ddr_burst_mover: pipe-in FIFO, readback FIFO level and DDR read responder modelled here.
module tb_ddr_burst_mover;
  localparam int ADDR_W = 24, DATA_W = 64, RF_DEPTH = 512, RF_UW = 9, MAX_OUT = 8, LAT = 10;

  logic              phy_clk = 1'b0;
  logic              reset_phy_clk_n = 1'b0;
  logic              local_init_done = 1'b1;
  logic              start_write = 1'b0, start_read = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0, num_beats = '0;
  logic              wf_empty = 1'b1;
  logic [31:0]       wf_q = '0;
  logic              wf_rdreq;
  logic [RF_UW-1:0]  rf_usedw = '0;
  logic [DATA_W-1:0] rf_data;
  logic              rf_wrreq;
  logic [ADDR_W-1:0] local_address;
  logic [DATA_W-1:0] local_wdata;
  logic [7:0]        local_be;
  logic              local_size, local_burstbegin, local_write_req, local_read_req;
  logic              local_ready = 1'b1;
  logic [DATA_W-1:0] local_rdata = '0;
  logic              local_rdata_valid = 1'b0;
  logic              busy, done, err;

  ddr_burst_mover dut (
    .phy_clk(phy_clk), .reset_phy_clk_n(reset_phy_clk_n), .local_init_done(local_init_done),
    .start_write(start_write), .start_read(start_read), .base_addr(base_addr), .num_beats(num_beats),
    .wf_empty(wf_empty), .wf_q(wf_q), .wf_rdreq(wf_rdreq),
    .rf_usedw(rf_usedw), .rf_data(rf_data), .rf_wrreq(rf_wrreq),
    .local_address(local_address), .local_wdata(local_wdata), .local_be(local_be),
    .local_size(local_size), .local_burstbegin(local_burstbegin),
    .local_write_req(local_write_req), .local_read_req(local_read_req), .local_ready(local_ready),
    .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 phy_clk = ~phy_clk;

  typedef struct {int due; logic [23:0] addr;} rsp_t;

  int vecs = 0, errs = 0;
  int cyc = 0;
  logic [31:0] wfq[$];
  rsp_t        rq[$];
  logic [23:0] wr_addr[$];
  logic [63:0] wr_data[$];
  logic        wr_bb[$];
  logic [63:0] rf_cap[$];
  int rd_acc = 0, wr_acc = 0, rdreq_cnt = 0, push_cnt = 0, done_cnt = 0;
  int done_cyc = 0, last_push_cyc = 0, bench_out = 0, max_out = 0, viol = 0;
  logic pop_wf = 1'b0, push_seen = 1'b0;
  int level = 0, drain_mode = 0;

  function automatic logic [63:0] mem(input logic [23:0] a);
    return {8'hA5, a, 8'h3C, ~a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag, input logic exp_err);
    chk({tag, " data"}, {rf_data, local_wdata}, '0);
    chk({tag, " ctl"}, {wf_rdreq, rf_wrreq, local_address, local_be, local_size, local_burstbegin,
                        local_write_req, local_read_req, busy, done, err},
        {2'b00, 24'h0, 8'hFF, 1'b1, 5'b0, exp_err});
  endtask

  task automatic start_job(input logic w, input logic r, input logic [23:0] b, input logic [23:0] n);
    @(posedge phy_clk); #1;
    start_write = w; start_read = r; base_addr = b; num_beats = n;
    @(posedge phy_clk); #1;
    start_write = 1'b0; start_read = 1'b0;
  endtask

  task automatic load_words(input int first, input int count);
    @(posedge phy_clk); #1;
    for (int k = 0; k < count; k++) wfq.push_back(32'(first + k));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge phy_clk); n++; end
    chk({tag, " done seen"}, 128'(done_cnt != d0), 128'(1));
  endtask

  always @(posedge phy_clk) cyc <= cyc + 1;

  // Observe accepted traffic just before the edge that commits it.
  always @(negedge phy_clk) begin
    rsp_t r;
    pop_wf = wf_rdreq;
    push_seen = rf_wrreq;
    if (!reset_phy_clk_n) bench_out = 0;
    else begin
      if (wf_rdreq) rdreq_cnt++;
      if (local_write_req && local_ready) begin
        wr_acc++;
        wr_addr.push_back(local_address);
        wr_data.push_back(local_wdata);
        wr_bb.push_back(local_burstbegin);
      end
      if (local_read_req && local_ready) begin
        if (bench_out >= MAX_OUT || int'(rf_usedw) + bench_out + 1 > RF_DEPTH) viol++;
        r.due = cyc + LAT; r.addr = local_address;
        rq.push_back(r);
        rd_acc++;
        bench_out++;
      end
      if (local_rdata_valid && bench_out > 0) bench_out--;
      if (bench_out > max_out) max_out = bench_out;
      if (rf_wrreq) begin push_cnt++; rf_cap.push_back(rf_data); last_push_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // Environment: pipe-in FIFO pops, readback FIFO level, and fixed-latency read responder.
  always @(posedge phy_clk) begin
    #1;
    if (pop_wf && wfq.size() > 0) void'(wfq.pop_front());
    wf_empty = (wfq.size() == 0);
    wf_q = wf_empty ? 32'h0 : wfq[0];
    if (drain_mode == 0)      level = level + (push_seen ? 1 : 0);
    else if (drain_mode == 2) level = level + (push_seen ? 1 : 0) - (level > 0 ? 1 : 0);
    rf_usedw = RF_UW'(level);
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      local_rdata_valid = 1'b1;
      local_rdata = mem(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      local_rdata_valid = 1'b0;
      local_rdata = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, w0, q0, p0, n, bad;
    repeat (3) @(negedge phy_clk);
    chk_rst("reset", 1'b0);
    @(posedge phy_clk); #1 reset_phy_clk_n = 1'b1;

    // Write 4 beats from words 1..8.
    load_words(1, 8);
    wr_addr.delete(); wr_data.delete(); wr_bb.delete();
    d0 = done_cnt; q0 = rdreq_cnt; w0 = wr_acc;
    start_job(1'b1, 1'b0, 24'h000010, 24'd4);
    wait_done(200, "w4");
    repeat (2) @(negedge phy_clk);
    chk("w4 beats", 128'(wr_acc - w0), 128'(4));
    for (int j = 0; j < 4 && j < wr_addr.size(); j++) begin
      chk("w4 addr", 128'(wr_addr[j]), 128'(24'h10 + 24'(j)));
      chk("w4 data", 128'(wr_data[j]), {64'h0, 32'(2*j + 2), 32'(2*j + 1)});
      chk("w4 burstbegin", 128'(wr_bb[j]), 128'(1));
    end
    chk("w4 rdreq", 128'(rdreq_cnt - q0), 128'(8));
    chk("w4 done once", 128'(done_cnt - d0), 128'(1));

    // Write held by local_ready low for 5 cycles.
    load_words(32'h11111111, 0);
    @(posedge phy_clk); #1;
    wfq.push_back(32'h11111111); wfq.push_back(32'h22222222);
    local_ready = 1'b0;
    w0 = wr_acc;
    start_job(1'b1, 1'b0, 24'h000100, 24'd1);
    n = 0;
    while (!local_write_req && n < 20) begin @(negedge phy_clk); n++; end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge phy_clk);
      chk("stall hold", 128'({local_write_req, local_address, local_wdata, local_burstbegin}),
          128'({1'b1, 24'h000100, 64'h22222222_11111111, (i == 0)}));
      if (i == 4) begin @(posedge phy_clk); #1 local_ready = 1'b1; end
    end
    wait_done(50, "stall");
    chk("stall one write", 128'(wr_acc - w0), 128'(1));

    // Read 3 beats with latency.
    @(posedge phy_clk); #1 level = 0; rf_usedw = '0;
    rf_cap.delete(); p0 = push_cnt; w0 = wr_acc;
    start_job(1'b0, 1'b1, 24'h000020, 24'd3);
    wait_done(100, "r3");
    chk("r3 pushes", 128'(push_cnt - p0), 128'(3));
    for (int j = 0; j < 3 && j < rf_cap.size(); j++)
      chk("r3 data", 128'(rf_cap[j]), 128'(mem(24'h20 + 24'(j))));
    chk("r3 done after last push", 128'(done_cyc > last_push_cyc), 128'(1));
    chk("r3 err", 128'(err), 128'(0));
    chk("r3 no writes", 128'(wr_acc - w0), 128'(0));

    // Read 20 beats against a nearly full readback FIFO.
    @(posedge phy_clk); #1;
    level = RF_DEPTH - 2; rf_usedw = RF_UW'(RF_DEPTH - 2); drain_mode = 1;
    max_out = 0; viol = 0; rf_cap.delete(); p0 = push_cnt; r0 = rd_acc;
    start_job(1'b0, 1'b1, 24'h000200, 24'd20);
    n = 0;
    while (rd_acc - r0 < 8 && n < 500) begin @(negedge phy_clk); n++; end
    chk("usedw phaseA progress", 128'(rd_acc - r0 >= 8), 128'(1));
    chk("usedw phaseA max outstanding", 128'(max_out), 128'(2));
    @(posedge phy_clk); #1 drain_mode = 2;
    wait_done(1500, "usedw");
    chk("usedw pushes", 128'(push_cnt - p0), 128'(20));
    bad = 0;
    for (int j = 0; j < rf_cap.size(); j++) if (rf_cap[j] !== mem(24'h200 + 24'(j))) bad++;
    chk("usedw data order", 128'(bad), 128'(0));
    chk("usedw credit violations", 128'(viol), 128'(0));
    chk("usedw outstanding range", 128'(max_out > 2 && max_out <= MAX_OUT), 128'(1));
    @(posedge phy_clk); #1 drain_mode = 0; level = 0; rf_usedw = '0;

    // Address wrap.
    load_words(32'h100, 4);
    wr_addr.delete(); wr_data.delete(); wr_bb.delete();
    start_job(1'b1, 1'b0, 24'hFFFFFF, 24'd2);
    wait_done(100, "wrap");
    chk("wrap count", 128'(wr_addr.size()), 128'(2));
    if (wr_addr.size() >= 2) begin
      chk("wrap addr0", 128'(wr_addr[0]), 128'(24'hFFFFFF));
      chk("wrap addr1", 128'(wr_addr[1]), 128'(24'h000000));
    end

    // Both starts together: write wins.
    load_words(32'h200, 4);
    w0 = wr_acc; r0 = rd_acc; q0 = rdreq_cnt;
    start_job(1'b1, 1'b1, 24'h000040, 24'd2);
    wait_done(100, "both");
    chk("both writes", 128'(wr_acc - w0), 128'(2));
    chk("both no reads", 128'(rd_acc - r0), 128'(0));
    chk("both rdreq", 128'(rdreq_cnt - q0), 128'(4));

    // Zero-length job: done two cycles after start, no traffic.
    w0 = wr_acc; r0 = rd_acc;
    @(posedge phy_clk); #1 start_write = 1'b1; base_addr = 24'h000050; num_beats = '0;
    @(posedge phy_clk); #1 start_write = 1'b0;
    @(negedge phy_clk);
    chk("n0 fin cycle", 128'({busy, done, local_write_req, local_read_req}), 128'(0));
    @(negedge phy_clk);
    chk("n0 done pulse", 128'({busy, done}), 128'(2'b01));
    @(negedge phy_clk);
    chk("n0 done ends", 128'(done), 128'(0));
    chk("n0 no traffic", 128'((wr_acc - w0) + (rd_acc - r0)), 128'(0));

    // Start ignored before calibration.
    @(posedge phy_clk); #1 local_init_done = 1'b0;
    d0 = done_cnt;
    start_job(1'b1, 1'b0, 24'h000060, 24'd1);
    repeat (4) @(negedge phy_clk);
    chk("no init busy", 128'(busy), 128'(0));
    chk("no init done", 128'(done_cnt - d0), 128'(0));
    @(posedge phy_clk); #1 local_init_done = 1'b1;

    // Reset while reads are outstanding; late data must flag err.
    r0 = rd_acc;
    start_job(1'b0, 1'b1, 24'h000080, 24'd3);
    n = 0;
    while (rd_acc - r0 < 3 && n < 50) begin @(negedge phy_clk); n++; end
    chk("rst reads issued", 128'(rd_acc - r0), 128'(3));
    @(posedge phy_clk); #1 reset_phy_clk_n = 1'b0;
    @(negedge phy_clk);
    chk_rst("rst held", 1'b0);
    @(posedge phy_clk); #1 reset_phy_clk_n = 1'b1;
    p0 = push_cnt;
    n = 0;
    while (rq.size() > 0 && n < 60) begin @(negedge phy_clk); n++; end
    repeat (3) @(negedge phy_clk);
    chk("rst responses drained", 128'(rq.size()), 128'(0));
    chk_rst("rst late data", 1'b1);
    chk("rst no push", 128'(push_cnt - p0), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
